// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse receive path: receive states,
// error-code bit positions and the default watchdog limit.
package mouse_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP   = 1;

  // 2 ms at a 50 MHz system clock
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data lines plus a
// registered copy of the clock line that yields a single-cycle falling-edge strobe.
module ps2_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic sync_data,
  output logic fall_strobe
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;

  always_comb begin
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
  end

  // Reset to the idle-high line level so leaving reset never fakes an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign sync_data   = data_sync_q;
  assign fall_strobe = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB-first, odd parity, stop).
// Optional stalled-frame watchdog: define MOUSE_RX_TIMEOUT_EN.
module mouse_receiver
   import mouse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_MOUSE_IN,
   input  logic       DATA_MOUSE_IN,
   input  logic       READ_ENABLE,
   output logic [7:0] BYTE_READ,
   output logic [1:0] BYTE_ERROR_CODE,
   output logic       BYTE_READY
);

   logic syncData;
   logic fallStrobe;

   ps2_edge_sync edgeSync (
      .clock       (CLK),
      .reset       (RESET),
      .ps2_clk_in  (CLK_MOUSE_IN),
      .ps2_data_in (DATA_MOUSE_IN),
      .sync_data   (syncData),
      .fall_strobe (fallStrobe)
   );

   rx_state_e  stateQ, stateD;
   logic [7:0] shiftQ, shiftD;
   logic [2:0] bitCntQ, bitCntD;
   logic       parityQ, parityD;
   logic [7:0] byteQ, byteD;
   logic [1:0] errQ, errD;
   logic       readyQ, readyD;

`ifdef MOUSE_RX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wdQ, wdD;
`endif

   // Next-state logic: walks start/data/parity/stop on each falling-edge strobe,
   // and (when compiled in) lets the watchdog abandon a stalled frame
   always_comb begin
      stateD  = stateQ;
      shiftD  = shiftQ;
      bitCntD = bitCntQ;
      parityD = parityQ;
      byteD   = byteQ;
      errD    = errQ;
      readyD  = 1'b0;

      case (stateQ)
         S_IDLE: begin
            if (fallStrobe && READ_ENABLE && !syncData) begin
               shiftD  = '0;
               bitCntD = '0;
               stateD  = S_DATA;
            end
         end
         S_DATA: begin
            if (fallStrobe) begin
               shiftD  = {syncData, shiftQ[7:1]};
               bitCntD = bitCntQ + 3'd1;
               if (bitCntQ == 3'd7) begin
                  stateD = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (fallStrobe) begin
               parityD = syncData;
               stateD  = S_STOP;
            end
         end
         S_STOP: begin
            if (fallStrobe) begin
               byteD             = shiftQ;
               errD[ERR_PARITY]  = ~^{shiftQ, parityQ};
               errD[ERR_STOP]    = ~syncData;
               readyD            = 1'b1;
               stateD            = S_IDLE;
            end
         end
         default: stateD = S_IDLE;
      endcase

`ifdef MOUSE_RX_TIMEOUT_EN
      wdD = wdQ;
      if (stateQ == S_IDLE || fallStrobe) begin
         wdD = '0;
      end else if (wdQ == WD_LIMIT) begin
         wdD    = '0;
         stateD = S_IDLE;
      end else begin
         wdD = wdQ + 1'b1;
      end
`endif
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stateQ  <= S_IDLE;
         shiftQ  <= '0;
         bitCntQ <= '0;
         parityQ <= 1'b0;
         byteQ   <= '0;
         errQ    <= '0;
         readyQ  <= 1'b0;
`ifdef MOUSE_RX_TIMEOUT_EN
         wdQ     <= '0;
`endif
      end else begin
         stateQ  <= stateD;
         shiftQ  <= shiftD;
         bitCntQ <= bitCntD;
         parityQ <= parityD;
         byteQ   <= byteD;
         errQ    <= errD;
         readyQ  <= readyD;
`ifdef MOUSE_RX_TIMEOUT_EN
         wdQ     <= wdD;
`endif
      end
   end

   assign BYTE_READ       = byteQ;
   assign BYTE_ERROR_CODE = errQ;
   assign BYTE_READY      = readyQ;

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed self-checking bench for mouse_receiver; PS/2 clock is scaled to
// 40 system cycles per bit to keep the run short.
module tb_mouse_receiver;

   localparam int HALF = 20;

   logic       clock;
   logic       reset;
   logic       mouseClk;
   logic       mouseData;
   logic       readEnable;
   logic [7:0] byteRead;
   logic [1:0] byteErrorCode;
   logic       byteReady;

   int checks = 0;
   int passes = 0;

   int         readyCnt = 0;
   int         readyRun = 0;
   int         readyMaxRun = 0;
   logic [7:0] seenByte = 8'h00;
   logic [1:0] seenErr = 2'b00;
   logic [7:0] firstByte = 8'h00;

   mouse_receiver #(.TIMEOUT_CYCLES(2000)) dut (
      .CLK             (clock),
      .RESET           (reset),
      .CLK_MOUSE_IN    (mouseClk),
      .DATA_MOUSE_IN   (mouseData),
      .READ_ENABLE     (readEnable),
      .BYTE_READ       (byteRead),
      .BYTE_ERROR_CODE (byteErrorCode),
      .BYTE_READY      (byteReady)
   );

   // 50 MHz system clock
   initial clock = 1'b0;
   always #10 clock = ~clock;

   // Ready-strobe monitor: counts pulses, longest run, and captures outputs at the pulse
   always @(negedge clock) begin
      if (byteReady) begin
         readyCnt = readyCnt + 1;
         readyRun = readyRun + 1;
         if (readyRun > readyMaxRun) readyMaxRun = readyRun;
         seenByte = byteRead;
         seenErr  = byteErrorCode;
         if (readyCnt == 1) firstByte = byteRead;
      end else begin
         readyRun = 0;
      end
   end

   task automatic clearMonitor();
      @(negedge clock);
      readyCnt    = 0;
      readyRun    = 0;
      readyMaxRun = 0;
      seenByte    = 8'h00;
      seenErr     = 2'b00;
      firstByte   = 8'h00;
   endtask

   function automatic logic [10:0] makeFrame(input logic [7:0] d, input logic p, input logic s);
      return {s, p, d, 1'b0};
   endfunction

   task automatic applyStimulus(input logic b);
      mouseData = b;
      repeat (HALF) @(negedge clock);
      mouseClk = 1'b0;
      repeat (HALF) @(negedge clock);
      mouseClk = 1'b1;
   endtask

   task automatic sendBits(input logic [10:0] frame, input int first, input int last);
      for (int i = first; i <= last; i++) applyStimulus(frame[i]);
      mouseData = 1'b1;
      repeat (HALF) @(negedge clock);
   endtask

   task automatic testReset();
      reset = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++; if (byteRead !== 8'h00) $display("[TB] FAIL reset_byte: got %h expected 00", byteRead); else passes++;
      checks++; if (byteErrorCode !== 2'b00) $display("[TB] FAIL reset_err: got %b expected 00", byteErrorCode); else passes++;
      checks++; if (byteReady !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", byteReady); else passes++;
   endtask

   task automatic testGoodFrame();
      clearMonitor();
      sendBits(makeFrame(8'hFA, 1'b1, 1'b1), 0, 10);
      checks++; if (seenByte !== 8'hFA) $display("[TB] FAIL good_byte: got %h expected fa", seenByte); else passes++;
      checks++; if (seenErr !== 2'b00) $display("[TB] FAIL good_err: got %b expected 00", seenErr); else passes++;
      checks++; if (readyCnt !== 1) $display("[TB] FAIL good_pulses: got %0d expected 1", readyCnt); else passes++;
      checks++; if (readyMaxRun !== 1) $display("[TB] FAIL good_pulse_width: got %0d expected 1", readyMaxRun); else passes++;
      repeat (10) @(negedge clock);
      checks++; if (byteRead !== 8'hFA) $display("[TB] FAIL good_hold: got %h expected fa", byteRead); else passes++;
   endtask

   task automatic testParityError();
      clearMonitor();
      sendBits(makeFrame(8'hFA, 1'b0, 1'b1), 0, 10);
      checks++; if (seenByte !== 8'hFA) $display("[TB] FAIL parity_byte: got %h expected fa", seenByte); else passes++;
      checks++; if (seenErr !== 2'b01) $display("[TB] FAIL parity_err: got %b expected 01", seenErr); else passes++;
      checks++; if (readyCnt !== 1) $display("[TB] FAIL parity_pulses: got %0d expected 1", readyCnt); else passes++;
   endtask

   task automatic testStopError();
      clearMonitor();
      sendBits(makeFrame(8'h00, 1'b1, 1'b0), 0, 10);
      checks++; if (seenByte !== 8'h00) $display("[TB] FAIL stop_byte: got %h expected 00", seenByte); else passes++;
      checks++; if (seenErr !== 2'b10) $display("[TB] FAIL stop_err: got %b expected 10", seenErr); else passes++;
      checks++; if (readyCnt !== 1) $display("[TB] FAIL stop_pulses: got %0d expected 1", readyCnt); else passes++;
   endtask

   task automatic testReadDisable();
      clearMonitor();
      readEnable = 1'b0;
      sendBits(makeFrame(8'h55, 1'b1, 1'b1), 0, 10);
      checks++; if (readyCnt !== 0) $display("[TB] FAIL disabled_pulses: got %0d expected 0", readyCnt); else passes++;
      checks++; if (byteRead !== 8'h00) $display("[TB] FAIL disabled_hold: got %h expected 00", byteRead); else passes++;
      readEnable = 1'b1;
      clearMonitor();
      sendBits(makeFrame(8'hAA, 1'b1, 1'b1), 0, 10);
      checks++; if (seenByte !== 8'hAA) $display("[TB] FAIL reenable_byte: got %h expected aa", seenByte); else passes++;
      checks++; if (seenErr !== 2'b00) $display("[TB] FAIL reenable_err: got %b expected 00", seenErr); else passes++;
      checks++; if (readyCnt !== 1) $display("[TB] FAIL reenable_pulses: got %0d expected 1", readyCnt); else passes++;
   endtask

   task automatic testEnableDrop();
      logic [10:0] f;
      f = makeFrame(8'h3C, 1'b1, 1'b1);
      clearMonitor();
      applyStimulus(f[0]);
      readEnable = 1'b0;
      sendBits(f, 1, 10);
      readEnable = 1'b1;
      checks++; if (seenByte !== 8'h3C) $display("[TB] FAIL drop_byte: got %h expected 3c", seenByte); else passes++;
      checks++; if (seenErr !== 2'b00) $display("[TB] FAIL drop_err: got %b expected 00", seenErr); else passes++;
      checks++; if (readyCnt !== 1) $display("[TB] FAIL drop_pulses: got %0d expected 1", readyCnt); else passes++;
   endtask

   task automatic testResetMidframe();
      logic [10:0] f;
      f = makeFrame(8'hF4, 1'b0, 1'b1);
      clearMonitor();
      for (int i = 0; i <= 5; i++) applyStimulus(f[i]);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++; if (byteRead !== 8'h00) $display("[TB] FAIL midreset_byte: got %h expected 00", byteRead); else passes++;
      checks++; if (byteErrorCode !== 2'b00) $display("[TB] FAIL midreset_err: got %b expected 00", byteErrorCode); else passes++;
      checks++; if (byteReady !== 1'b0) $display("[TB] FAIL midreset_ready: got %b expected 0", byteReady); else passes++;
      readEnable = 1'b0;
      sendBits(f, 6, 10);
      readEnable = 1'b1;
      checks++; if (readyCnt !== 0) $display("[TB] FAIL midreset_pulses: got %0d expected 0", readyCnt); else passes++;
      clearMonitor();
      sendBits(f, 0, 10);
      checks++; if (seenByte !== 8'hF4) $display("[TB] FAIL after_reset_byte: got %h expected f4", seenByte); else passes++;
      checks++; if (seenErr !== 2'b00) $display("[TB] FAIL after_reset_err: got %b expected 00", seenErr); else passes++;
      checks++; if (readyCnt !== 1) $display("[TB] FAIL after_reset_pulses: got %0d expected 1", readyCnt); else passes++;
   endtask

   task automatic testBackToBack();
      logic [10:0] f1;
      logic [10:0] f2;
      f1 = makeFrame(8'h12, 1'b1, 1'b1);
      f2 = makeFrame(8'h81, 1'b1, 1'b1);
      clearMonitor();
      for (int i = 0; i <= 10; i++) applyStimulus(f1[i]);
      sendBits(f2, 0, 10);
      checks++; if (readyCnt !== 2) $display("[TB] FAIL b2b_pulses: got %0d expected 2", readyCnt); else passes++;
      checks++; if (firstByte !== 8'h12) $display("[TB] FAIL b2b_first: got %h expected 12", firstByte); else passes++;
      checks++; if (seenByte !== 8'h81) $display("[TB] FAIL b2b_second: got %h expected 81", seenByte); else passes++;
      checks++; if (seenErr !== 2'b00) $display("[TB] FAIL b2b_err: got %b expected 00", seenErr); else passes++;
   endtask

`ifdef MOUSE_RX_TIMEOUT_EN
   task automatic testTimeout();
      logic [10:0] f;
      f = makeFrame(8'hAA, 1'b1, 1'b1);
      clearMonitor();
      for (int i = 0; i <= 4; i++) applyStimulus(f[i]);
      repeat (2100) @(negedge clock);
      checks++; if (readyCnt !== 0) $display("[TB] FAIL timeout_pulses: got %0d expected 0", readyCnt); else passes++;
      sendBits(f, 0, 10);
      checks++; if (seenByte !== 8'hAA) $display("[TB] FAIL timeout_next_byte: got %h expected aa", seenByte); else passes++;
      checks++; if (seenErr !== 2'b00) $display("[TB] FAIL timeout_next_err: got %b expected 00", seenErr); else passes++;
      checks++; if (readyCnt !== 1) $display("[TB] FAIL timeout_next_pulses: got %0d expected 1", readyCnt); else passes++;
   endtask
`endif

   // Test sequence
   initial begin
      reset      = 1'b1;
      mouseClk   = 1'b1;
      mouseData  = 1'b1;
      readEnable = 1'b1;
      testReset();
      testGoodFrame();
      testParityError();
      testStopError();
      testReadDisable();
      testEnableDrop();
      testResetMidframe();
      testBackToBack();
`ifdef MOUSE_RX_TIMEOUT_EN
      testTimeout();
`endif
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
